// File: rtl/rr_select_arbiter.sv
// Four-channel round-robin arbiter driving a 2-to-4 decoder select/enable.
// Define RR_SELECT_ARBITER_TIMEOUT_EN to enforce a TIMEOUT-cycle limit on each grant.
module rr_select_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] sel_n;
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    logic       release_normal;
    logic       expire;
    logic       timeout_q, timeout_n;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_select_arbiter: TIMEOUT must be in 2..255");
    end

`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
    logic [7:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
    end

    // cnt counts completed GRANT cycles beyond the first; expiry on the TIMEOUT-th.
    always_comb begin
        expire = (state == GRANT) && (cnt == 8'(TIMEOUT - 1));
        cnt_n  = cnt;
        if (state == IDLE)
            cnt_n = '0;
        else if (!(release_normal || expire))
            cnt_n = cnt + 8'd1;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            timeout_q <= timeout_n;
        end
    end

    // First requesting channel at or after ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        sel_n          = sel;
        timeout_n      = 1'b0;
        release_normal = done | ~req[sel];
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (release_normal || expire) begin
                    state_n   = IDLE;
                    ptr_n     = sel + 2'd1;
                    timeout_n = ~release_normal;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sel_en  = (state == GRANT);
    assign busy    = (state == GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Self-checking bench for rr_select_arbiter: directed test-plan steps plus random traffic
// compared against a behavioural round-robin model.
module tb_rr_select_arbiter;

    localparam int unsigned TB_TIMEOUT = 4;
`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       sel_en;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit       m_en;
    int       m_sel;
    int       m_ptr;
    bit       m_to;
    int       m_held;

    rr_select_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .sel_en  (sel_en),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_edge();
        bit rel_normal;
        bit exp_to;
        if (rst) begin
            m_en = 0; m_sel = 0; m_ptr = 0; m_to = 0; m_held = 0;
        end else if (!m_en) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!m_en && req[c]) begin
                    m_en = 1; m_sel = c; m_held = 1;
                end
            end
        end else begin
            rel_normal = done || !req[m_sel];
            exp_to     = TO_EN && (m_held >= int'(TB_TIMEOUT));
            if (rel_normal || exp_to) begin
                m_en  = 0;
                m_ptr = (m_sel + 1) % 4;
                m_to  = !rel_normal;
            end else begin
                m_held++;
                m_to = 0;
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] q, input bit d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("sel",     int'(sel),     m_sel);
        chk("sel_en",  int'(sel_en),  int'(m_en));
        chk("busy",    int'(busy),    int'(m_en));
        chk("timeout", int'(timeout), int'(m_to));
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // Reset with all requests and done asserted
        step(1, 4'b1111, 1);
        step(1, 4'b1111, 1);
        chk("rst_sel", int'(sel), 0);
        chk("rst_en", int'(sel_en), 0);
        step(0, 4'b1111, 0);
        chk("first_grant", int'(sel), 0);

        // Rotation 0,1,2,3,0
        for (int g = 1; g <= 4; g++) begin
            step(0, 4'b1111, 1);
            chk("rot_gap", int'(sel_en), 0);
            step(0, 4'b1111, 0);
            chk("rot_sel", int'(sel), g % 4);
            chk("rot_en", int'(sel_en), 1);
        end
        step(0, 4'b1111, 1);
        step(0, 4'b0000, 0);

        // Pointer skip and wrap
        step(0, 4'b0100, 0);
        chk("skip_sel2", int'(sel), 2);
        step(0, 4'b0100, 1);
        step(0, 4'b1001, 0);
        chk("skip_sel3", int'(sel), 3);
        step(0, 4'b1001, 1);
        step(0, 4'b1001, 0);
        chk("wrap_sel0", int'(sel), 0);
        step(0, 4'b1001, 1);

        // Request drop without done; ptr is 1 here
        step(0, 4'b1010, 0);
        chk("drop_sel1", int'(sel), 1);
        step(0, 4'b1000, 0);
        chk("drop_rel", int'(sel_en), 0);
        step(0, 4'b1000, 0);
        chk("drop_sel3", int'(sel), 3);
        chk("drop_en", int'(sel_en), 1);
        step(0, 4'b0000, 0);

        // Grant held with done low
        step(0, 4'b0001, 0);
        for (int c = 0; c < 3; c++) step(0, 4'b0001, 0);
        chk("hold_en", int'(sel_en), 1);
`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
        step(0, 4'b0001, 0);
        chk("to_rel", int'(sel_en), 0);
        chk("to_pulse", int'(timeout), 1);
        step(0, 4'b0001, 0);
        chk("to_regrant", int'(sel_en), 1);
        chk("to_clear", int'(timeout), 0);
        chk("to_sel", int'(sel), 0);
`else
        for (int c = 0; c < 100; c++) step(0, 4'b0001, 0);
        chk("nto_en", int'(sel_en), 1);
        chk("nto_pulse", int'(timeout), 0);
`endif
        step(0, 4'b0001, 1);
        step(0, 4'b0000, 0);

        // Mid-grant reset
        step(0, 4'b0100, 0);
        chk("mid_sel2", int'(sel), 2);
        step(1, 4'b0100, 0);
        chk("mid_rst_sel", int'(sel), 0);
        chk("mid_rst_en", int'(sel_en), 0);
        step(0, 4'b0101, 0);
        chk("mid_ch0", int'(sel), 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic [3:0] q;
            q = 4'($urandom);
            if ($urandom_range(0, 3) == 0) q = q & 4'($urandom);
            step(($urandom_range(0, 49) == 0), q, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Four-channel round-robin arbiter that sits directly upstream of the 2-to-4 one-hot decoder. It drives the decoder's 2-bit select and enable. It picks one requesting channel at a time, holds the grant until the channel releases it, and then rotates priority. The decoder therefore only sees a stable, registered select while enable is high.

## Interface

Parameters:
- TIMEOUT, default 15: maximum number of cycles a grant may be held (range 2–255). Used only when the timeout feature is compiled in.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit i = channel i.
- done  input  1  release strobe from the granted channel; sampled only while granted.
- sel  output  2  granted channel index; feeds the decoder select.
- sel_en  output  1  grant valid; feeds the decoder enable.
- busy  output  1  high while in the GRANT state; identical to sel_en.
- timeout  output  1  one-cycle pulse when a grant is force-released; tied 0 when the feature is compiled out.

## Operation

- Two-state FSM: IDLE, GRANT. Internal 2-bit priority pointer ptr.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register that index into sel, set sel_en=1, go to GRANT.
  - If req == 0, stay in IDLE. sel keeps its last value and sel_en=0.
- GRANT:
  - sel is frozen.
  - release = done | ~req[sel] (or timeout expiry when compiled in).
  - On release: sel_en=0, ptr=sel+1 (mod 4, wraps 3→0), go to IDLE.
- Requests from other channels during GRANT are ignored. They are considered at the next IDLE evaluation.
- done while in IDLE is ignored.
- Simultaneous done and req drop count as a single release.
- Reset values: state=IDLE, ptr=0, sel=2'b00, sel_en=0, busy=0, timeout=0, timeout counter=0.
- Reset takes priority over all other events, including a mid-grant reset. The next edge with rst=1 forces the reset values, regardless of req or done.

## Timing

- Grant latency: req is sampled at edge N while in IDLE; sel and sel_en are valid after edge N. That is one cycle, with no combinational path from req to the outputs.
- Release latency: release is sampled at edge M; sel_en is low after edge M.
- At least one IDLE cycle always follows a release, so sel_en is low for at least one cycle between grants.
- Maximum grant rate is one grant every 2 cycles (e.g. every channel asserting done in its first granted cycle).
- sel changes only on the edge where sel_en rises. It never changes while sel_en=1.
- Timeout counting (compiled in):
  - The counter clears on entry to GRANT and increments each GRANT cycle.
  - If no other release has occurred when sel_en has been high for TIMEOUT cycles, the next edge forces a release and timeout=1 for exactly one cycle.
  - A normal release on the same edge as expiry takes precedence: timeout stays 0.

## Configuration

- Macro RR_SELECT_ARBITER_TIMEOUT_EN.
- Defined: 8-bit grant-duration counter active, TIMEOUT enforced, timeout output pulses as described.
- Undefined: no counter is instantiated, grants are held indefinitely until done or request drop, and timeout is constant 0.

## Test plan

- Reset: rst=1 for 2 cycles with req=4'b1111 and done=1 → sel=0, sel_en=0, busy=0, timeout=0 throughout. After rst falls, ch0 is granted one cycle later.
- Rotation: req=4'b1111 held; done pulsed in each granted cycle → grant sequence sel=0,1,2,3,0. sel_en alternates 1,0.
- Pointer skip and wrap: grant ch2 with req=4'b0100, then done → ptr=3. Next req=4'b1001 → sel=3. After its release, req=4'b1001 → sel=0.
- Request drop: ch1 granted and req[1] deasserted without done → sel_en=0 one edge later. A pending req[3] is granted after the dead cycle.
- Timeout (macro defined, TIMEOUT=4): req=4'b0001, done=0 → sel_en high for 4 cycles, then low with timeout=1 for one cycle, then ch0 re-granted after the dead cycle. With the macro undefined, sel_en stays high for 100+ cycles and timeout stays 0.
- Mid-grant reset: ch2 granted and rst asserted → the next edge gives sel=0, sel_en=0, ptr=0. With req=4'b0101 after reset, ch0 wins.
